ccd_frame_capture: RTL and testbench

Sensor-side pixel capture block: samples the raw 12-bit Bayer stream and frame/line valid strobes from the camera, and gates whole frames under start/stop control. Produces the qualified pixel stream plus pixel coordinates (data, data-valid, X/Y counters) consumed by the image-processing pipeline's line buffer, greyscale and convolution stages. Also maintains a running frame count for display and debug.

---
 rtl/ccd_frame_capture.sv | 128 ++++++++++++
 tb/tb_ccd_frame_capture.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_frame_capture.sv
// Sensor-side Bayer pixel capture: registers the raw camera stream, gates whole frames
// under start/stop control and emits qualified pixels with X/Y coordinates and a frame count.
module ccd_frame_capture #(
  parameter int DATA_W     = 12,
  parameter int LINE_WIDTH = 1280,
  parameter int X_W        = 11,
  parameter int Y_W        = 11,
  parameter int FCNT_W     = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic              iSTART,
  input  logic              iEND,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [X_W-1:0]    oX_Cont,
  output logic [Y_W-1:0]    oY_Cont,
  output logic [FCNT_W-1:0] oFrame_Cont,
  output logic              oBusy
);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;

  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_WIDTH - 1);

  state_t            state, state_next;
  logic [DATA_W-1:0] s_data;
  logic              s_fval, s_fval_d, s_lval, s_lval_d;
  logic              run;
  logic [X_W-1:0]    x, x_cur;
  logic [Y_W-1:0]    y, y_cur;
  logic              fval_rise, fval_fall, lval_fall;
  logic              frame_start, cap_en;

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update from the same pre-edge values, independent of process ordering.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      s_data   <= '0;
      s_fval   <= 1'b0;
      s_fval_d <= 1'b0;
      s_lval   <= 1'b0;
      s_lval_d <= 1'b0;
    end else begin
      s_data   <= iDATA;
      s_fval   <= iFVAL;
      s_fval_d <= s_fval;
      s_lval   <= iLVAL;
      s_lval_d <= s_lval;
    end
  end

  // Stop has priority so a simultaneous start/stop leaves capture disarmed.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)       run <= 1'b0;
    else if (iEND)   run <= 1'b0;
    else if (iSTART) run <= 1'b1;
  end

  assign fval_rise = s_fval & ~s_fval_d;
  assign fval_fall = ~s_fval & s_fval_d;
  assign lval_fall = ~s_lval & s_lval_d;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: the default assignment first guarantees no latch on any path.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (run) state_next = WAIT_FRAME;
      WAIT_FRAME: begin
        if (!run)           state_next = IDLE;
        else if (fval_rise) state_next = CAPTURE;
      end
      CAPTURE:    if (fval_fall) state_next = run ? WAIT_FRAME : IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // A pixel coincident with the FVAL rise belongs to the new frame at (0,0).
  assign frame_start = (state == WAIT_FRAME) & run & fval_rise;
  assign cap_en      = s_lval & s_fval & ((state == CAPTURE) | frame_start);
  assign x_cur       = frame_start ? '0 : x;
  assign y_cur       = frame_start ? '0 : y;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDATA       <= '0;
      oDVAL       <= 1'b0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oFrame_Cont <= '0;
      x           <= '0;
      y           <= '0;
    end else begin
      oDVAL <= cap_en;
      if (frame_start) begin
        oFrame_Cont <= oFrame_Cont + 1'b1;
        x           <= '0;
        y           <= '0;
      end
      if (cap_en) begin
        oDATA   <= s_data;
        oX_Cont <= x_cur;
        oY_Cont <= y_cur;
        if (x_cur == X_LAST) begin
          x <= '0;
          y <= y_cur + 1'b1;
        end else begin
          x <= x_cur + 1'b1;
        end
      end else if ((state == CAPTURE) && lval_fall && (x != '0)) begin
        // Short line: move to the next row; an exact-length line has already wrapped.
        x <= '0;
        y <= y + 1'b1;
      end
    end
  end

  assign oBusy = (state == CAPTURE);

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Scoreboard bench for ccd_frame_capture: a frame-level model queues expected pixels,
// and a negedge monitor pops and compares whenever the DUT asserts oDVAL.
module tb_ccd_frame_capture;

  localparam int DW = 12;
  localparam int LW = 4;
  localparam int XW = 11;
  localparam int YW = 11;
  localparam int FW = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] idata;
  logic          ifval, ilval, istart, iend;
  logic [DW-1:0] odata;
  logic          odval;
  logic [XW-1:0] ox;
  logic [YW-1:0] oy;
  logic [FW-1:0] ofcnt;
  logic          obusy;

  pix_t          expq[$];
  int            lens[$];
  logic [DW-1:0] fdata[$];
  pix_t          last = '0;
  logic [FW-1:0] fcnt_exp = '0;
  logic [DW-1:0] ramp = '0;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  ccd_frame_capture #(
    .DATA_W(DW), .LINE_WIDTH(LW), .X_W(XW), .Y_W(YW), .FCNT_W(FW)
  ) dut (
    .iCLK(clk), .iRST(rst_n), .iDATA(idata), .iFVAL(ifval), .iLVAL(ilval),
    .iSTART(istart), .iEND(iend), .oDATA(odata), .oDVAL(odval),
    .oX_Cont(ox), .oY_Cont(oy), .oFrame_Cont(ofcnt), .oBusy(obusy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pixels must match the queue in order; idle cycles must hold the last pixel.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (odval) begin
          check("pixel_pending", 64'(expq.size() > 0), 64'd1);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            check("pix_data", 64'(odata), 64'(e.d));
            check("pix_x", 64'(ox), 64'(e.x));
            check("pix_y", 64'(oy), 64'(e.y));
            last = e;
          end
        end else begin
          check("hold_outputs", 64'({odata, ox, oy}), 64'(last));
        end
      end
    end
  end

  task automatic fill_data(input bit inc);
    fdata.delete();
    foreach (lens[i]) begin
      for (int p = 0; p < lens[i]; p++) begin
        if (inc) begin
          fdata.push_back(ramp);
          ramp = ramp + 1'b1;
        end else begin
          fdata.push_back(DW'($urandom));
        end
      end
    end
  endtask

  // Coordinates straight from the rules: raster order, wrap at LW, short lines end their row.
  task automatic model_frame();
    int   x = 0;
    int   y = 0;
    int   k = 0;
    pix_t p;
    foreach (lens[i]) begin
      for (int j = 0; j < lens[i]; j++) begin
        p.d = fdata[k];
        p.x = XW'(x);
        p.y = YW'(y % (1 << YW));
        expq.push_back(p);
        k++;
        x++;
        if (x == LW) begin
          x = 0;
          y++;
        end
      end
      if (x != 0) begin
        x = 0;
        y++;
      end
    end
  endtask

  task automatic drive_frame(input bit lead, input bit cap, input int end_line, input int start_line);
    int k = 0;
    if (cap) begin
      model_frame();
      fcnt_exp = fcnt_exp + 1'b1;
    end
    @(negedge clk);
    ifval = 1'b1;
    if (!lead) @(negedge clk);
    for (int i = 0; i < lens.size(); i++) begin
      for (int p = 0; p < lens[i]; p++) begin
        ilval  = 1'b1;
        idata  = fdata[k];
        k++;
        iend   = (i == end_line) && (p == 0);
        istart = (i == start_line) && (p == 0);
        @(negedge clk);
      end
      ilval  = 1'b0;
      iend   = 1'b0;
      istart = 1'b0;
      idata  = DW'($urandom);
      @(negedge clk);
      if (i == 0) check("busy_mid_frame", 64'(obusy), 64'(cap));
    end
    ifval = 1'b0;
    repeat (4) @(negedge clk);
    check("frame_count", 64'(ofcnt), 64'(fcnt_exp));
    check("busy_after_frame", 64'(obusy), 64'd0);
  endtask

  task automatic pulse(input bit s, input bit e);
    @(negedge clk);
    istart = s;
    iend   = e;
    @(negedge clk);
    istart = 1'b0;
    iend   = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 64'(odata), 64'd0);
    check({tag, "_dval"}, 64'(odval), 64'd0);
    check({tag, "_x"}, 64'(ox), 64'd0);
    check({tag, "_y"}, 64'(oy), 64'd0);
    check({tag, "_fcnt"}, 64'(ofcnt), 64'd0);
    check({tag, "_busy"}, 64'(obusy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; idata = '0; ifval = 1'b0; ilval = 1'b0; istart = 1'b0; iend = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Two 3x4 frames of an incrementing ramp, second with LVAL coincident with the FVAL rise.
    pulse(1'b1, 1'b0);
    lens = '{4, 4, 4};
    fill_data(1'b1); drive_frame(1'b0, 1'b1, -1, -1);
    fill_data(1'b1); drive_frame(1'b1, 1'b1, -1, -1);
    check("two_frames_count", 64'(ofcnt), 64'd2);

    // Armed while a frame is already in progress: that frame is skipped, the next is whole.
    pulse(1'b0, 1'b1);
    fill_data(1'b0); drive_frame(1'b0, 1'b0, -1, 1);
    fill_data(1'b0); drive_frame(1'b0, 1'b1, -1, -1);

    // Stop during line 1: frame completes, following frame ignored.
    fill_data(1'b0); drive_frame(1'b0, 1'b1, 1, -1);
    fill_data(1'b0); drive_frame(1'b0, 1'b0, -1, -1);

    // Short line, full line, over-long line.
    pulse(1'b1, 1'b0);
    lens = '{2, 4, 6};
    fill_data(1'b0); drive_frame(1'b0, 1'b1, -1, -1);
    pulse(1'b0, 1'b1);

    // Simultaneous start and stop leaves capture disarmed.
    pulse(1'b1, 1'b1);
    lens = '{4, 4};
    fill_data(1'b0); drive_frame(1'b1, 1'b0, -1, -1);

    // Asynchronous reset in the middle of a captured frame.
    pulse(1'b1, 1'b0);
    @(negedge clk);
    ifval = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_before_reset", 64'(obusy), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    last     = '0;
    fcnt_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < LW; p++) begin
      ilval = 1'b1;
      idata = DW'($urandom);
      @(negedge clk);
    end
    ilval = 1'b0;
    @(negedge clk);
    ifval = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_fcnt", 64'(ofcnt), 64'd0);
    check("post_reset_busy", 64'(obusy), 64'd0);

    // Re-armed: randomized frame shapes and data.
    pulse(1'b1, 1'b0);
    for (int f = 0; f < 8; f++) begin
      lens.delete();
      for (int l = 0, n = $urandom_range(1, 4); l < n; l++)
        lens.push_back($urandom_range(1, 6));
      fill_data(1'b0);
      drive_frame(1'($urandom_range(0, 1)), 1'b1, -1, -1);
    end
    pulse(1'b0, 1'b1);

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(expq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
